alu_cmd_seq: RTL and testbench
==============================

# alu_cmd_seq

Command sequencer stage directly upstream of the 8-bit combinational ALU (operands `A`, `B`, select `ALU_Sel`, result `ALU_Out`). It accepts operation commands through a valid/ready handshake and buffers them in a small FIFO. It presents one command at a time to the ALU through registered outputs, then captures `ALU_Out` into a result register that a consumer drains with a second valid/ready handshake.

## Interface
- `DEPTH`, default 4: command FIFO depth; must be a power of 2 and ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals !full.
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `cmd_op` in 3: ALU opcode.
- `alu_a` out 8: registered, drives ALU `A`.
- `alu_b` out 8: registered, drives ALU `B`.
- `alu_sel` out 3: registered, drives ALU `ALU_Sel`.
- `alu_out` in 8: ALU result.
- `res_valid` out 1: result register holds an unconsumed result.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 8: captured result.
- `res_op` out 3: opcode that produced `res_data`.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: high when state ≠ IDLE or count ≠ 0.
- `res_err` out 1: only with `ALU_SEQ_ERR_FLAG_EN`; see Configuration.

## Operation
- **Push rule:** FIFO push on `cmd_valid && cmd_ready`.
  - `cmd_ready` is `!full` only. Push while full is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full are both honoured, and `count` is unchanged.
- **FSM states:** IDLE, EXEC, RESULT.
  - **IDLE:** if count ≠ 0, pop the head into `alu_a`/`alu_b`/`alu_sel` and go to EXEC. Otherwise stay in IDLE.
  - **EXEC:** exactly one cycle. At the closing edge, capture `alu_out` into `res_data` and `alu_sel` into `res_op`, then go to RESULT.
  - **RESULT:** `res_valid`=1, and `res_data`/`res_op` are held stable while `res_ready`=0.
    - On `res_ready`, if count ≠ 0: pop and go to EXEC in the same edge. Back-to-back throughput is one result per 2 cycles.
    - On `res_ready`, if count = 0: go to IDLE.
- **ALU-facing outputs:** `alu_*` change only on a pop and otherwise hold their last value. The ALU input is therefore stable for the whole EXEC cycle.
- **Opcodes:** the sequencer is opcode-agnostic. Any 3-bit opcode is issued, including 110/111, for which the ALU returns 0.
- **Arithmetic:** no width extension; `res_data` is exactly the 8-bit `alu_out` (mod-256 wrap for add/sub).
- **Reset (`rst_n`=0 at an edge):**
  - State → IDLE; FIFO pointers and `count` → 0.
  - `alu_a`/`alu_b` → 0, `alu_sel` → 3'b000.
  - `res_data` → 0, `res_op` → 0, `res_valid` → 0, `res_err` → 0.
  - `cmd_ready` → 1 from the first cycle after reset (combinational from count).
  - A command or result in flight at reset is discarded with no partial output.

## Timing
- **Minimum latency:** command accepted at edge N → popped at edge N+1 → captured at edge N+2. `res_valid` is high in the cycle after edge N+2, i.e. 3 edges after acceptance.
- **FIFO storage:** a push into an empty FIFO is visible to the pop logic one cycle later. There is no bypass.
- **Capacity:** with `res_ready` held low, at most DEPTH commands queue in the FIFO plus one in RESULT.
- **`count`** is registered and updates on the edge of the push/pop.

## Configuration
- **`ALU_SEQ_ERR_FLAG_EN` defined:**
  - Adds the `res_err` port, captured alongside `res_data`.
  - `res_err` = 1 when the captured op is 3'b101 with `alu_b` = 0 (divide by zero), or when the op is 3'b110 or 3'b111.
  - It is held with `res_valid` and cleared on reset.
- **Not defined:** the port and its logic are absent, and all other behaviour is identical.

## Structure
- **Shared package `alu_pkg`:**
  - opcode localparams `ALU_OP_ADD`=000, `ALU_OP_SUB`=001, `ALU_OP_AND`=010, `ALU_OP_OR`=011, `ALU_OP_NOT`=100, `ALU_OP_DIV`=101;
  - state enum `alu_seq_state_t` {IDLE, EXEC, RESULT};
  - packed command struct `alu_cmd_t` {a[7:0], b[7:0], op[2:0]}.
- **Sub-module `alu_cmd_fifo`:** synchronous FIFO of `alu_cmd_t`, parameterised by DEPTH. It exposes full/empty/count and push/pop.
- The FSM and result register live in `alu_cmd_seq`. The ALU is instantiated by the parent, not inside this block.

## Test plan
- Single ADD a=8'h7F b=8'h01, `res_ready`=1 → `res_valid` 3 edges after acceptance, `res_data`=8'h80, `res_op`=000; `busy` returns low the cycle after the handshake.
- SUB a=8'h05 b=8'h07, then DIV a=8'd100 b=8'd7 back-to-back with `res_ready`=1 → results 8'hFE then 8'd14, 2 cycles apart, in order.
- `res_ready`=0, push 6 commands → 5 accepted, `cmd_ready`=0 with `count`=4. The first `res_data`/`res_op` stay stable until `res_ready` rises, then the remaining results drain in FIFO order.
- DIV a=8'd9 b=0 and op=3'b111 → `res_data`=0 for both; with `ALU_SEQ_ERR_FLAG_EN`, `res_err`=1 for both and 0 for a following AND 8'hF0&8'h3C=8'h30.
- Reset asserted while in EXEC with 2 commands queued → next cycle: `count`=0, `res_valid`=0, `alu_a`/`alu_b`/`alu_sel`=0, `cmd_ready`=1. No stale result appears after reset release.

Source files
------------

// File: rtl/alu_cmd_seq_pkg.sv
// alu_pkg: shared types for the ALU command sequencer.
//   - ALU opcode constants
//   - sequencer FSM state enum
//   - packed command struct carried through the FIFO
package alu_pkg;
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_AND = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_NOT = 3'b100;
  localparam logic [2:0] ALU_OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } alu_seq_state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_seq_if.sv
// alu_cmd_seq_if: bundle of the sequencer's command, ALU and result signals.
//   cmd_*    : command valid/ready handshake and payload
//   alu_*    : registered operands/select towards the ALU, alu_out back
//   res_*    : result valid/ready handshake and captured result
//   count    : FIFO occupancy, busy: sequencer activity
//   res_err  : error flag, present only with ALU_SEQ_ERR_FLAG_EN
// slave modport = the sequencer, master modport = its surroundings.
interface alu_cmd_seq_if #(parameter int DEPTH = 4) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [2:0]    cmd_op;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [2:0]    res_op;
  logic [CW-1:0] count;
  logic          busy;
`ifdef ALU_SEQ_ERR_FLAG_EN
  logic          res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_op,
           count, busy, res_err
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_op,
           count, busy, res_err
  );
`else
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_op,
           count, busy
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_op,
           count, busy
  );
`endif
endinterface

// File: rtl/alu_cmd_seq_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, no write-to-read bypass.
//   clk, rst_n        : clock, synchronous active-low reset (pointers/count)
//   i_push, i_data    : write request (ignored when full)
//   i_pop, o_data     : read request (ignored when empty), head entry
//   o_full, o_empty   : status, o_count: occupancy 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  alu_cmd_t      i_data,
  input  logic          i_pop,
  output alu_cmd_t      o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  alu_cmd_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  // Push is gated by full alone: a same-cycle pop does not free a slot.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of an 8-bit combinational ALU.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_cmd_seq_if.slave (command in, ALU drive, result out)
// Commands are buffered in alu_cmd_fifo, issued one at a time on registered
// alu_* outputs, and the ALU result is captured after a single EXEC cycle.
// Optional macro ALU_SEQ_ERR_FLAG_EN adds res_err (div-by-zero / op 110,111).
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic         clk,
  input logic         rst_n,
  alu_cmd_seq_if.slave bus
);
  alu_cmd_t       w_in, w_head;
  logic           w_full, w_empty, w_push, w_pop;
  logic [CW-1:0]  w_count;
  alu_seq_state_t r_state;
  logic [7:0]     r_alu_a, r_alu_b, r_res_data;
  logic [2:0]     r_alu_sel, r_res_op;

  assign w_in   = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
  assign w_push = bus.cmd_valid && !w_full;
  // Pop from IDLE, or from RESULT in the same edge the result is taken.
  assign w_pop  = !w_empty &&
                  ((r_state == IDLE) || (r_state == RESULT && bus.res_ready));

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_res_data <= '0;
      r_res_op   <= '0;
    end else begin
      // ALU operands only move on a pop, so they are stable through EXEC.
      if (w_pop) begin
        r_alu_a   <= w_head.a;
        r_alu_b   <= w_head.b;
        r_alu_sel <= w_head.op;
      end
      case (r_state)
        IDLE:    if (w_pop) r_state <= EXEC;
        EXEC: begin
          r_res_data <= bus.alu_out;
          r_res_op   <= r_alu_sel;
          r_state    <= RESULT;
        end
        RESULT:  if (bus.res_ready) r_state <= w_empty ? IDLE : EXEC;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ERR_FLAG_EN
  logic r_res_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_res_err <= 1'b0;
    else if (r_state == EXEC)
      r_res_err <= ((r_alu_sel == ALU_OP_DIV) && (r_alu_b == 8'd0)) ||
                   (r_alu_sel[2:1] == 2'b11);
  end
  assign bus.res_err = r_res_err;
`endif

  assign bus.cmd_ready = !w_full;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.res_valid = (r_state == RESULT);
  assign bus.res_data  = r_res_data;
  assign bus.res_op    = r_res_op;
  assign bus.count     = w_count;
  assign bus.busy      = (r_state != IDLE) || (w_count != '0);
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed + randomized bench for alu_cmd_seq with a
// behavioural ALU and a queue-based result scoreboard.
module tb_alu_cmd_seq;
  import alu_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_seq_if #(.DEPTH(DEPTH)) bus ();
  alu_cmd_seq #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [7:0] alu_ref(input logic [7:0] a, b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~a;
      3'd5: return (b == 8'd0) ? 8'd0 : a / b;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic err_ref(input logic [7:0] b, input logic [2:0] op);
    return (op == 3'd5 && b == 8'd0) || (op >= 3'd6);
  endfunction

  always_comb bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  typedef struct { logic [7:0] d; logic [2:0] op; logic e; } exp_t;
  exp_t       q[$];
  exp_t       cq[$];
  logic [7:0] gd[$];
  logic [2:0] go[$];
  logic       ge[$];
  int         gc[$];
  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input logic v, input logic [7:0] a, b, input logic [2:0] op);
    bus.cmd_valid = v; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
  endtask

  function automatic exp_t mk(input logic [7:0] a, b, input logic [2:0] op);
    exp_t e;
    e.d = alu_ref(a, b, op); e.op = op; e.e = err_ref(b, op);
    return e;
  endfunction

  // Sample results for n cycles; a result is recorded when taken.
  task automatic collect(input int n);
    gd.delete(); go.delete(); ge.delete(); gc.delete();
    for (int k = 0; k < n; k++) begin
      if (bus.res_valid && bus.res_ready) begin
        gd.push_back(bus.res_data); go.push_back(bus.res_op); gc.push_back(k);
`ifdef ALU_SEQ_ERR_FLAG_EN
        ge.push_back(bus.res_err);
`else
        ge.push_back(1'b0);
`endif
      end
      step();
    end
  endtask

  task automatic chk_collected(input string tag);
    chk({tag, "_n"}, gd.size(), cq.size());
    for (int i = 0; i < gd.size() && i < cq.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), gd[i], cq[i].d);
      chk($sformatf("%s_op%0d", tag, i), go[i], cq[i].op);
`ifdef ALU_SEQ_ERR_FLAG_EN
      chk($sformatf("%s_err%0d", tag, i), ge[i], cq[i].e);
`endif
    end
  endtask

  initial begin
    int acc;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    exp_t e;

    rst_n = 1'b0; bus.res_ready = 1'b0;
    set_cmd(1'b0, 8'd0, 8'd0, 3'd0);
    step(); step();
    chk("rst_count", bus.count, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_alu", {bus.alu_a, bus.alu_b, 5'(bus.alu_sel)}, 0);
    chk("rst_res", {bus.res_data, 5'(bus.res_op)}, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1; step();

    // Single ADD: latency and busy release.
    bus.res_ready = 1'b1;
    set_cmd(1'b1, 8'h7F, 8'h01, ALU_OP_ADD);
    chk("t1_ready", bus.cmd_ready, 1);
    step(); bus.cmd_valid = 1'b0;
    chk("t1_e0_valid", bus.res_valid, 0);
    chk("t1_e0_count", bus.count, 1);
    step();
    chk("t1_e1_valid", bus.res_valid, 0);
    chk("t1_e1_alu_a", bus.alu_a, 8'h7F);
    step();
    chk("t1_e2_valid", bus.res_valid, 1);
    chk("t1_data", bus.res_data, 8'h80);
    chk("t1_op", bus.res_op, 3'b000);
    chk("t1_busy_hi", bus.busy, 1);
    step();
    chk("t1_busy_lo", bus.busy, 0);
    chk("t1_valid_lo", bus.res_valid, 0);

    // SUB then DIV back-to-back.
    set_cmd(1'b1, 8'h05, 8'h07, ALU_OP_SUB); step();
    set_cmd(1'b1, 8'd100, 8'd7, ALU_OP_DIV); step();
    bus.cmd_valid = 1'b0;
    collect(8);
    cq.delete();
    cq.push_back(mk(8'h05, 8'h07, ALU_OP_SUB));
    cq.push_back(mk(8'd100, 8'd7, ALU_OP_DIV));
    chk_collected("t2");
    chk("t2_d0_const", (gd.size() > 0) ? gd[0] : 8'hxx, 8'hFE);
    chk("t2_d1_const", (gd.size() > 1) ? gd[1] : 8'hxx, 8'd14);
    chk("t2_spacing", (gc.size() > 1) ? gc[1] - gc[0] : -1, 2);

    // Capacity: 6 pushes with res_ready low, 5 accepted.
    bus.res_ready = 1'b0; acc = 0; cq.delete();
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      set_cmd(1'b1, ra, rb, rop);
      if (bus.cmd_ready) begin acc++; cq.push_back(mk(ra, rb, rop)); end
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("t3_acc", acc, 5);
    chk("t3_count", bus.count, 4);
    chk("t3_ready", bus.cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", bus.res_valid, 1);
      chk("t3_hold_data", bus.res_data, cq[0].d);
      chk("t3_hold_op", bus.res_op, cq[0].op);
      step();
    end
    bus.res_ready = 1'b1;
    collect(14);
    chk_collected("t3");

    // Error cases followed by a clean AND.
    bus.res_ready = 1'b0; cq.delete();
    set_cmd(1'b1, 8'd9, 8'd0, ALU_OP_DIV); cq.push_back(mk(8'd9, 8'd0, ALU_OP_DIV)); step();
    ra = 8'($urandom); rb = 8'($urandom);
    set_cmd(1'b1, ra, rb, 3'b111); cq.push_back(mk(ra, rb, 3'b111)); step();
    set_cmd(1'b1, 8'hF0, 8'h3C, ALU_OP_AND); cq.push_back(mk(8'hF0, 8'h3C, ALU_OP_AND)); step();
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
    collect(12);
    chk_collected("t4");
    chk("t4_div0", (gd.size() > 0) ? gd[0] : 8'hxx, 8'h00);
    chk("t4_and", (gd.size() > 2) ? gd[2] : 8'hxx, 8'h30);

    // Reset while in EXEC with two commands queued.
    bus.res_ready = 1'b0; cq.delete();
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(1, 255)); rb = 8'($urandom);
      set_cmd(1'b1, ra, rb, 3'($urandom)); cq.push_back(mk(ra, rb, 3'd0));
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("t5_count3", bus.count, 3);
    bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
    chk("t5_exec_count", bus.count, 2);
    chk("t5_exec_valid", bus.res_valid, 0);
    rst_n = 1'b0; step();
    chk("t5_count", bus.count, 0);
    chk("t5_valid", bus.res_valid, 0);
    chk("t5_alu", {bus.alu_a, bus.alu_b, 5'(bus.alu_sel)}, 0);
    chk("t5_ready", bus.cmd_ready, 1);
    rst_n = 1'b1; bus.res_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.res_valid || bus.count != 0) acc++;
      step();
    end
    chk("t5_no_stale", acc, 0);

    // Randomized traffic against the scoreboard.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      set_cmd(($urandom % 2) == 0, ra, rb, rop);
      bus.res_ready = ($urandom % 3) != 0;
      if (bus.cmd_valid && bus.cmd_ready) q.push_back(mk(ra, rb, rop));
      if (bus.res_valid && bus.res_ready) begin
        if (q.size() == 0) chk("rnd_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_data", bus.res_data, e.d);
          chk("rnd_op", bus.res_op, e.op);
`ifdef ALU_SEQ_ERR_FLAG_EN
          chk("rnd_err", bus.res_err, e.e);
`endif
        end
      end
      step();
    end
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
    for (int c = 0; c < 60 && q.size() != 0; c++) begin
      if (bus.res_valid) begin
        e = q.pop_front();
        chk("drain_data", bus.res_data, e.d);
        chk("drain_op", bus.res_op, e.op);
      end
      step();
    end
    chk("drain_empty", q.size(), 0);
    step();
    chk("drain_idle", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
